// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and constants for the direct-sound engine
package audio_pkg;

  typedef logic signed [7:0] sample_t;

  localparam logic TIMER0 = 1'b0;
  localparam logic TIMER1 = 1'b1;

  // Mix accumulator width: 9 bits covers one halved/full sample sum, plus headroom per channel.
  function automatic int calc_sumw(input int num_ch);
    return 9 + $clog2(num_ch);
  endfunction

endpackage

// File: rtl/ds_byte_fifo.sv
// rtl/ds_byte_fifo.sv - per-channel word-write / byte-read sample FIFO
// Holds the channel's current sample and raises a DMA request when it drains to half.
module ds_byte_fifo
  import audio_pkg::*;
#(
  parameter int FIFO_WORDS = 8,
  localparam int CAP = 4 * FIFO_WORDS,
  localparam int CW = $clog2(CAP) + 1
) (
  input  logic          clock,
  input  logic          rst_b,
  input  logic          wr,
  input  logic [31:0]   wdata,
  input  logic          clr,
  input  logic          pop,
  output sample_t       sample,
  output logic [CW-1:0] count,
  output logic          ovf,
  output logic          req
);

  localparam int WPW = $clog2(FIFO_WORDS);
  localparam logic [CW-1:0] WR_LIMIT = CW'(CAP - 4);
  localparam logic [CW-1:0] HALF = CW'(CAP / 2);

  logic [31:0]    mem [FIFO_WORDS];
  logic [WPW-1:0] wptr;
  logic [WPW-1:0] rword;
  logic [1:0]     rbyte;
  logic           wr_ok;
  logic           pop_hit;
  logic [CW-1:0]  post_pop;

  // Acceptance uses the count before any same-cycle pop.
  always_comb begin
    wr_ok    = wr && (count <= WR_LIMIT);
    pop_hit  = pop && (count != '0);
    post_pop = count - CW'(pop_hit);
  end

  always_ff @(posedge clock) begin
    if (rst_b && !clr && wr_ok) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_b) begin
      wptr   <= '0;
      rword  <= '0;
      rbyte  <= '0;
      count  <= '0;
      sample <= '0;
      ovf    <= 1'b0;
      req    <= 1'b0;
    end else if (clr) begin
      wptr   <= '0;
      rword  <= '0;
      rbyte  <= '0;
      count  <= '0;
      sample <= '0;
      ovf    <= 1'b0;
      req    <= 1'b0;
    end else begin
      if (wr) begin
        if (wr_ok) begin
          wptr <= wptr + WPW'(1);
        end else begin
          ovf <= 1'b1;
        end
      end
      if (pop_hit) begin
        sample <= mem[rword][{rbyte, 3'b000} +: 8];
        rbyte  <= rbyte + 2'd1;
        if (rbyte == 2'd3) begin
          rword <= rword + WPW'(1);
        end
      end
      // Empty pops still request DMA so a starved channel keeps asking.
      req   <= pop && (post_pop <= HALF);
      count <= post_pop + (wr_ok ? CW'(4) : CW'(0));
    end
  end

endmodule

// File: rtl/direct_sound_multi.sv
// rtl/direct_sound_multi.sv - NUM_CH direct-sound channels mixed to left/right
module direct_sound_multi
  import audio_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int FIFO_WORDS = 8,
  parameter int OUT_W = 24,
  localparam int CAP = 4 * FIFO_WORDS,
  localparam int CW = $clog2(CAP) + 1
) (
  input  logic                     clock,
  input  logic                     rst_b,
  input  logic [NUM_CH-1:0]        fifo_wr,
  input  logic [31:0]              fifo_wdata,
  input  logic [NUM_CH-1:0]        fifo_clr,
  input  logic [1:0]               timer_ovf,
  input  logic [NUM_CH-1:0]        timer_sel,
  input  logic [NUM_CH-1:0]        vol_full,
  input  logic [NUM_CH-1:0]        en_l,
  input  logic [NUM_CH-1:0]        en_r,
  output logic [NUM_CH-1:0]        sound_req,
  output logic [NUM_CH*CW-1:0]     fifo_count,
  output logic [NUM_CH-1:0]        fifo_ovf,
  output logic signed [OUT_W-1:0]  out_l,
  output logic signed [OUT_W-1:0]  out_r,
  output logic                     out_strobe
);

  localparam int SUMW = calc_sumw(NUM_CH);
  localparam int SHIFT = OUT_W - SUMW;

  sample_t                 samples [NUM_CH];
  logic [NUM_CH-1:0]       pop;
  logic signed [SUMW-1:0]  sum_l;
  logic signed [SUMW-1:0]  sum_r;
  sample_t                 scaled;
  logic                    mix_pend;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    assign pop[ch] = (timer_sel[ch] == TIMER1) ? timer_ovf[1] : timer_ovf[0];

    ds_byte_fifo #(
      .FIFO_WORDS(FIFO_WORDS)
    ) u_fifo (
      .clock (clock),
      .rst_b (rst_b),
      .wr    (fifo_wr[ch]),
      .wdata (fifo_wdata),
      .clr   (fifo_clr[ch]),
      .pop   (pop[ch]),
      .sample(samples[ch]),
      .count (fifo_count[ch*CW +: CW]),
      .ovf   (fifo_ovf[ch]),
      .req   (sound_req[ch])
    );
  end

  always_comb begin
    sum_l  = '0;
    sum_r  = '0;
    scaled = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scaled = vol_full[i] ? samples[i] : (samples[i] >>> 1);
      if (en_l[i]) sum_l = sum_l + SUMW'(scaled);
      if (en_r[i]) sum_r = sum_r + SUMW'(scaled);
    end
  end

  // Samples settle one cycle after a pop/clear; the mix is latched the cycle after that.
  always_ff @(posedge clock) begin
    if (!rst_b) begin
      mix_pend   <= 1'b0;
      out_strobe <= 1'b0;
      out_l      <= '0;
      out_r      <= '0;
    end else begin
      mix_pend   <= |(pop | fifo_clr);
      out_strobe <= mix_pend;
      if (mix_pend) begin
        out_l <= OUT_W'(sum_l) <<< SHIFT;
        out_r <= OUT_W'(sum_r) <<< SHIFT;
      end
    end
  end

endmodule

// File: tb/tb_direct_sound_multi.sv
// tb/tb_direct_sound_multi.sv - directed and random checks of direct_sound_multi
module tb_direct_sound_multi;

  logic        clock = 1'b0;
  logic        rst_b;
  logic [1:0]  fifo_wr, fifo_clr, timer_ovf, timer_sel, vol_full, en_l, en_r;
  logic [31:0] fifo_wdata;
  logic [1:0]  sound_req, fifo_ovf;
  logic [11:0] fifo_count;
  logic signed [23:0] out_l, out_r;
  logic        out_strobe;

  always #5 clock = ~clock;

  direct_sound_multi #(.NUM_CH(2), .FIFO_WORDS(8), .OUT_W(24)) dut (
    .clock(clock), .rst_b(rst_b), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
    .fifo_clr(fifo_clr), .timer_ovf(timer_ovf), .timer_sel(timer_sel),
    .vol_full(vol_full), .en_l(en_l), .en_r(en_r), .sound_req(sound_req),
    .fifo_count(fifo_count), .fifo_ovf(fifo_ovf), .out_l(out_l), .out_r(out_r),
    .out_strobe(out_strobe)
  );

  // Reference: each channel is a byte ring of capacity 32 with a head and a size.
  logic [7:0] mb [2][32];
  int  m_head [2];
  int  m_size [2];
  int  m_samp [2];
  bit  m_ovf [2];
  bit  m_req [2];
  int  m_l, m_r;
  bit  m_strobe, m_pend;
  int  tests = 0;
  int  fails = 0;
  int  first_req;
  int  strobes;

  localparam int SCALE = 16384;

  function automatic int half_floor(int s);
    return (s >= 0) ? s / 2 : -((-s + 1) / 2);
  endfunction

  function automatic int mix(logic [1:0] en);
    int sum;
    sum = 0;
    for (int c = 0; c < 2; c++) begin
      if (en[c]) sum += vol_full[c] ? m_samp[c] : half_floor(m_samp[c]);
    end
    return sum * SCALE;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("count%0d", c), int'(fifo_count[c*6 +: 6]), m_size[c]);
      chk($sformatf("req%0d", c), int'(sound_req[c]), int'(m_req[c]));
      chk($sformatf("ovf%0d", c), int'(fifo_ovf[c]), int'(m_ovf[c]));
    end
    chk("strobe", int'(out_strobe), int'(m_strobe));
    chk("out_l", out_l, m_l);
    chk("out_r", out_r, m_r);
  endtask

  task automatic tick();
    bit ev;
    int pre;
    if (!rst_b) begin
      for (int c = 0; c < 2; c++) begin
        m_head[c] = 0; m_size[c] = 0; m_samp[c] = 0; m_ovf[c] = 0; m_req[c] = 0;
      end
      m_l = 0; m_r = 0; m_strobe = 0; m_pend = 0;
    end else begin
      m_strobe = m_pend;
      if (m_pend) begin
        m_l = mix(en_l);
        m_r = mix(en_r);
      end
      ev = 0;
      for (int c = 0; c < 2; c++) begin
        m_req[c] = 0;
        if (fifo_clr[c]) begin
          m_head[c] = 0; m_size[c] = 0; m_samp[c] = 0; m_ovf[c] = 0; ev = 1;
        end else begin
          pre = m_size[c];
          if (timer_ovf[timer_sel[c]]) begin
            ev = 1;
            if (pre > 0) begin
              m_samp[c] = int'($signed(mb[c][m_head[c]]));
              m_head[c] = (m_head[c] + 1) % 32;
              m_size[c]--;
            end
            m_req[c] = (m_size[c] <= 16);
          end
          if (fifo_wr[c]) begin
            if (pre <= 28) begin
              for (int b = 0; b < 4; b++) begin
                mb[c][(m_head[c] + m_size[c]) % 32] = fifo_wdata[8*b +: 8];
                m_size[c]++;
              end
            end else begin
              m_ovf[c] = 1;
            end
          end
        end
      end
      m_pend = ev;
    end
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic wr_word(int c, logic [31:0] w);
    fifo_wdata = w;
    fifo_wr = 2'b01 << c;
    tick();
    fifo_wr = 2'b00;
  endtask

  task automatic pulse(logic [1:0] t);
    timer_ovf = t;
    tick();
    timer_ovf = 2'b00;
  endtask

  task automatic clear(logic [1:0] m);
    fifo_clr = m;
    tick();
    fifo_clr = 2'b00;
  endtask

  int ord_full [4] = '{-1, 1, 127, -128};
  int ord_half [4] = '{-1, 0, 63, -64};

  initial begin
    rst_b = 1'b0; fifo_wr = 0; fifo_clr = 0; timer_ovf = 0; timer_sel = 0;
    vol_full = 0; en_l = 0; en_r = 0; fifo_wdata = 0;
    for (int c = 0; c < 2; c++) begin
      m_head[c] = 0; m_size[c] = 0; m_samp[c] = 0; m_ovf[c] = 0; m_req[c] = 0;
    end
    m_l = 0; m_r = 0; m_strobe = 0; m_pend = 0;

    tick(); tick();
    chk("rst_out_l", out_l, 0);
    chk("rst_count", int'(fifo_count), 0);
    rst_b = 1'b1;
    strobes = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      strobes += int'(out_strobe);
    end
    chk("idle_strobes", strobes, 0);

    // Byte order and volume scaling on ch0, left only
    en_l = 2'b01; en_r = 2'b00; vol_full = 2'b01;
    wr_word(0, 32'h807F_01FF);
    for (int i = 0; i < 4; i++) begin
      pulse(2'b01);
      tick();
      chk("ord_full_l", out_l, ord_full[i] * SCALE);
      chk("ord_full_r", out_r, 0);
    end
    vol_full = 2'b00;
    wr_word(0, 32'h807F_01FF);
    for (int i = 0; i < 4; i++) begin
      pulse(2'b01);
      tick();
      chk("ord_half_l", out_l, ord_half[i] * SCALE);
      chk("ord_half_r", out_r, 0);
    end

    // Underrun and DMA request threshold
    vol_full = 2'b01;
    clear(2'b11);
    for (int i = 0; i < 8; i++) wr_word(0, $urandom);
    chk("fill_count", int'(fifo_count[5:0]), 32);
    first_req = -1;
    for (int i = 0; i < 40; i++) begin
      pulse(2'b01);
      if (sound_req[0] && first_req < 0) first_req = i;
    end
    chk("first_req", first_req, 15);
    tick(); tick();

    // Overflow then clear
    clear(2'b01);
    for (int i = 0; i < 8; i++) wr_word(0, $urandom);
    wr_word(0, 32'hDEAD_BEEF);
    chk("ovf_count", int'(fifo_count[5:0]), 32);
    chk("ovf_flag", int'(fifo_ovf[0]), 1);
    clear(2'b01);
    chk("clr_count", int'(fifo_count[5:0]), 0);
    chk("clr_flag", int'(fifo_ovf[0]), 0);

    // Simultaneous write/pop, then clear overriding both
    for (int i = 0; i < 7; i++) wr_word(0, $urandom);
    fifo_wdata = $urandom; fifo_wr = 2'b01; timer_ovf = 2'b01;
    tick();
    chk("wr_pop_count", int'(fifo_count[5:0]), 31);
    fifo_clr = 2'b01;
    tick();
    fifo_clr = 2'b00; fifo_wr = 2'b00; timer_ovf = 2'b00;
    chk("clr_wr_pop_count", int'(fifo_count[5:0]), 0);
    chk("clr_wr_pop_req", int'(sound_req[0]), 0);
    tick();
    chk("clr_sample_l", out_l, 0);

    // Timer routing: ch0 on timer 0, ch1 on timer 1
    clear(2'b11);
    timer_sel = 2'b10; en_l = 2'b11; en_r = 2'b10; vol_full = 2'b11;
    fifo_wdata = $urandom; fifo_wr = 2'b11;
    tick();
    fifo_wr = 2'b00;
    pulse(2'b10);
    chk("route_ch0", int'(fifo_count[5:0]), 4);
    chk("route_ch1", int'(fifo_count[11:6]), 3);
    tick(); tick(); tick();
    pulse(2'b11);
    chk("both_ch0", int'(fifo_count[5:0]), 3);
    chk("both_ch1", int'(fifo_count[11:6]), 2);
    chk("both_t1_strobe", int'(out_strobe), 0);
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) chk("both_t2_strobe", int'(out_strobe), 1);
      strobes += int'(out_strobe);
    end
    chk("both_strobes", strobes, 1);

    // Reset with a strobe pending
    wr_word(0, $urandom);
    pulse(2'b01);
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    tick();
    chk("rst_pend_strobe", int'(out_strobe), 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      fifo_wdata = $urandom;
      fifo_wr    = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      fifo_clr   = ($urandom_range(0, 40) == 0) ? 2'($urandom) : 2'b00;
      timer_ovf  = ($urandom_range(0, 1) == 0) ? 2'($urandom) : 2'b00;
      if ($urandom_range(0, 15) == 0) begin
        timer_sel = 2'($urandom); vol_full = 2'($urandom);
        en_l = 2'($urandom); en_r = 2'($urandom);
      end
      tick();
    end
    fifo_wr = 0; fifo_clr = 0; timer_ovf = 0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/direct_sound_multi.md
# direct_sound_multi

Parametrised direct-sound engine for the GBA audio path. It provides NUM_CH PCM channels instead of the fixed A/B pair, and each channel owns a word-write/byte-read FIFO of configurable depth. On a selected timer overflow, each channel pops one signed 8-bit sample and raises a one-cycle DMA request when its FIFO is half empty. The enabled channels are mixed into left and right OUT_W-bit samples for the final mixer ahead of the codec.

## Interface
Parameters:
- NUM_CH, 2, number of direct-sound channels (≥1)
- FIFO_WORDS, 8, FIFO depth in 32-bit words (power of two, ≥2); byte capacity CAP = 4·FIFO_WORDS
- OUT_W, 24, output sample width (≥ 9 + $clog2(NUM_CH))

Ports:
- clock  in  1  system clock; **one clock domain, all logic on posedge clock**
- rst_b  in  1  **synchronous, active-low reset**
- fifo_wr  in  NUM_CH  per-channel FIFO word-write strobe
- fifo_wdata  in  32  write word, shared by all channels; byte 0 = [7:0] plays first
- fifo_clr  in  NUM_CH  per-channel FIFO clear pulse
- timer_ovf  in  2  timer 0/1 overflow pulses
- timer_sel  in  NUM_CH  per-channel timer select (0 = timer 0, 1 = timer 1)
- vol_full  in  NUM_CH  1 = 100 % volume, 0 = 50 % volume
- en_l, en_r  in  NUM_CH each  per-channel left/right output enable
- sound_req  out  NUM_CH  one-cycle DMA request pulse
- fifo_count  out  NUM_CH×($clog2(CAP)+1)  bytes held per channel
- fifo_ovf  out  NUM_CH  sticky write-overflow flag
- out_l, out_r  out  OUT_W signed  mixed output samples
- out_strobe  out  1  one-cycle pulse when out_l/out_r update

## Operation
- Per-channel FIFO:
  - Storage is FIFO_WORDS × 32-bit words, with a word write pointer, a read pointer of word index plus byte index, and a byte count.
  - Pointers wrap modulo FIFO_WORDS.
- Write:
  - Accepted when count ≤ CAP−4; the channel's count increases by 4.
  - Otherwise the word is dropped, fifo_ovf[ch] is set, and count is unchanged.
- Pop:
  - Occurs when timer_ovf[timer_sel[ch]] is high.
  - If count > 0, the current byte is loaded into the channel's sample register, the byte index advances, and count decreases by 1.
  - If count = 0, the sample register holds its last value.
- DMA request:
  - sound_req[ch] pulses whenever a pop occurs on that channel and the post-pop count ≤ CAP/2.
  - This includes pops on an empty FIFO.
- Write and pop in the same cycle: both take effect; count changes by +3. The write-acceptance check uses the pre-pop count.
- Clear:
  - Pointers, count and the sample register are set to 0, and fifo_ovf[ch] is cleared.
  - Clear overrides a write or pop in the same cycle; no sound_req is generated that cycle.
- Mixing:
  - Scaled sample s = vol_full ? sample : sample >>> 1 (arithmetic shift).
  - Each side sums s over its enabled channels into SUMW = 9 + $clog2(NUM_CH) bits. This width cannot overflow, so no saturation is applied.
  - The sum is left-shifted by OUT_W−SUMW into the output.
- Recompute: the mix is recomputed after any pop or clear on any channel. out_strobe marks each update.

## Timing
- Reset (rst_b = 0 at a clock edge): all FIFOs empty, all pointers 0, sample registers 0, fifo_ovf 0, sound_req 0, out_l = out_r = 0, out_strobe 0.
- Write latency: fifo_wr in cycle t → fifo_count updated at t+1.
- Pop latency:
  - timer_ovf at t → sample register, fifo_count and sound_req valid at t+1.
  - out_l/out_r registered and out_strobe at t+2.
- Enable changes: changes to en_l/en_r/vol_full take effect only at the next strobe.
- Both timers overflow in one cycle: each channel pops at most once; there is a single out_strobe.
- Reset asserted mid-stream: state returns to reset values on that edge; any pending strobe is discarded.

## Structure
- Package audio_pkg:
  - sample_t (logic signed [7:0])
  - TIMER0/TIMER1 select constants
  - function to compute SUMW
- Sub-module ds_byte_fifo, one instance per channel:
  - Contains the storage, pointers, count, overflow flag, sample register and sound_req generation.
- Top level:
  - Generate loop over the channels.
  - Timer-select mux.
  - Registered mixer and strobe pipeline.

## Test plan
- Reset then idle: all outputs 0, out_strobe never pulses.
- Ordering and volume: NUM_CH=2; write 0x80_7F_01_FF to ch0; enable ch0 left only at full volume; four timer-0 overflows. Required:
  - out_l = −1, 1, 127, −128, each scaled by 2^(OUT_W−10).
  - out_r = 0 throughout.
  - Repeated at vol_full=0, out_l = −1, 0, 63, −64 (scaled the same way).
- Underrun and DMA: fill 8 words (count 32), then 40 pops. Required:
  - sound_req first pulses on the pop reaching count 16, then on every later pop.
  - The sample holds its last byte once count = 0.
- Overflow: with 8 words already written, a 9th write leaves count 32 and sets fifo_ovf; a following fifo_clr gives count 0 and fifo_ovf 0.
- Simultaneous events:
  - Write plus pop at count 28: count becomes 31.
  - Clear plus write plus pop: count 0, sample 0, no sound_req.
- Timer routing: ch0 on timer 0, ch1 on timer 1.
  - A timer_ovf=2'b10 pulse pops ch1 only.
  - timer_ovf=2'b11 pops both and produces exactly one out_strobe, at t+2.
